// File: rtl/sync_dp_ram_be_if.sv
// One port of the true-dual-port byte-enable RAM. The master drives the request;
// the slave (the RAM) returns read data and valid.
interface sync_dp_ram_be_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  CSel_S;
  logic                  WrEn_S;
  logic [BE_WIDTH-1:0]   BEn_S;
  logic [DATA_WIDTH-1:0] WrData_D;
  logic [ADDR_WIDTH-1:0] Addr_D;
  logic [DATA_WIDTH-1:0] RdData_D;
  logic                  RdValid_S;

  modport master (output CSel_S, WrEn_S, BEn_S, WrData_D, Addr_D,
                  input  RdData_D, RdValid_S);
  modport slave  (input  CSel_S, WrEn_S, BEn_S, WrData_D, Addr_D,
                  output RdData_D, RdValid_S);
endinterface

// File: rtl/sync_dp_ram_be.sv
// Inferable true-dual-port RAM with byte enables, read-first across ports, port A wins
// on shared write bytes. Define SYNC_DP_RAM_COLL_CHECK_EN to build the Coll_SO detector.
module sync_dp_ram_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_REGS   = 0
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  sync_dp_ram_be_if.slave   port_a,
  sync_dp_ram_be_if.slave   port_b,
  output logic              Coll_SO
);
  localparam int                  BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic                  wr_a_s, wr_b_s, rd_a_s, rd_b_s;
  logic [DATA_WIDTH-1:0] rd_q_a_r, rd_q_b_r;

  // Out-of-range writes are dropped; reads always proceed.
  assign wr_a_s = port_a.CSel_S & port_a.WrEn_S & ({1'b0, port_a.Addr_D} < DEPTH_L);
  assign wr_b_s = port_b.CSel_S & port_b.WrEn_S & ({1'b0, port_b.Addr_D} < DEPTH_L);
  assign rd_a_s = port_a.CSel_S & ~port_a.WrEn_S;
  assign rd_b_s = port_b.CSel_S & ~port_b.WrEn_S;

  // Byte-wise array writes; A is scheduled after B so A's bytes win on a shared address.
  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (wr_b_s && port_b.BEn_S[i]) begin
        mem[port_b.Addr_D][8*i +: 8] <= port_b.WrData_D[8*i +: 8];
      end
      if (wr_a_s && port_a.BEn_S[i]) begin
        mem[port_a.Addr_D][8*i +: 8] <= port_a.WrData_D[8*i +: 8];
      end
    end
  end

  // Array output registers: unreset, hold until the next read, see the pre-write word.
  always_ff @(posedge Clk_CI) begin
    if (rd_a_s) begin
      rd_q_a_r <= mem[port_a.Addr_D];
    end
    if (rd_b_s) begin
      rd_q_b_r <= mem[port_b.Addr_D];
    end
  end

  generate
    if (OUT_REGS == 1) begin : g_oreg
      logic [1:0]            vld_a_r, vld_b_r;
      logic [DATA_WIDTH-1:0] out_a_r, out_b_r;

      // Two-stage valid pipeline plus resettable output register per port.
      always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
          vld_a_r <= 2'b00;
          vld_b_r <= 2'b00;
          out_a_r <= '0;
          out_b_r <= '0;
        end else begin
          vld_a_r <= {vld_a_r[0], rd_a_s};
          vld_b_r <= {vld_b_r[0], rd_b_s};
          if (vld_a_r[0]) begin
            out_a_r <= rd_q_a_r;
          end
          if (vld_b_r[0]) begin
            out_b_r <= rd_q_b_r;
          end
        end
      end

      assign port_a.RdValid_S = vld_a_r[1];
      assign port_b.RdValid_S = vld_b_r[1];
      assign port_a.RdData_D  = out_a_r;
      assign port_b.RdData_D  = out_b_r;
    end else begin : g_noreg
      logic vld_a_r, vld_b_r;

      // Single-stage valid tracking straight off the array output.
      always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
          vld_a_r <= 1'b0;
          vld_b_r <= 1'b0;
        end else begin
          vld_a_r <= rd_a_s;
          vld_b_r <= rd_b_s;
        end
      end

      assign port_a.RdValid_S = vld_a_r;
      assign port_b.RdValid_S = vld_b_r;
      assign port_a.RdData_D  = rd_q_a_r;
      assign port_b.RdData_D  = rd_q_b_r;
    end
  endgenerate

`ifdef SYNC_DP_RAM_COLL_CHECK_EN
  logic coll_s, coll_r;

  assign coll_s = port_a.CSel_S & port_a.WrEn_S & port_b.CSel_S & port_b.WrEn_S &
                  (port_a.Addr_D == port_b.Addr_D) & (|(port_a.BEn_S & port_b.BEn_S));

  // One-cycle registered collision flag.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      coll_r <= 1'b0;
    end else begin
      coll_r <= coll_s;
    end
  end

  assign Coll_SO = coll_r;

  // Simulation-only notice of overlapping same-address writes.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RBI) begin
      assert (!coll_s) else $error("sync_dp_ram_be: write-write collision at addr %h", port_a.Addr_D);
    end
  end
`else
  assign Coll_SO = 1'b0;
`endif

endmodule

// File: tb/tb_sync_dp_ram_be.sv
// Directed bench: dut0 = default 64-bit/OUT_REGS=0, dut1 = 32-bit/OUT_REGS=1.
module tb_sync_dp_ram_be;
  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic coll0, coll1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sync_dp_ram_be_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) ifa0 ();
  sync_dp_ram_be_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) ifb0 ();
  sync_dp_ram_be_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32)) ifa1 ();
  sync_dp_ram_be_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32)) ifb1 ();

  sync_dp_ram_be #(.ADDR_WIDTH(10), .DATA_DEPTH(1024), .DATA_WIDTH(64), .OUT_REGS(0)) dut0 (
    .Clk_CI(clk), .Rst_RBI(rst0_n), .port_a(ifa0), .port_b(ifb0), .Coll_SO(coll0));

  sync_dp_ram_be #(.ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .OUT_REGS(1)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst1_n), .port_a(ifa1), .port_b(ifb1), .Coll_SO(coll1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a0(input logic cs, input logic we, input logic [7:0] ben,
                    input logic [63:0] d, input logic [9:0] ad);
    ifa0.CSel_S = cs; ifa0.WrEn_S = we; ifa0.BEn_S = ben; ifa0.WrData_D = d; ifa0.Addr_D = ad;
  endtask

  task automatic b0(input logic cs, input logic we, input logic [7:0] ben,
                    input logic [63:0] d, input logic [9:0] ad);
    ifb0.CSel_S = cs; ifb0.WrEn_S = we; ifb0.BEn_S = ben; ifb0.WrData_D = d; ifb0.Addr_D = ad;
  endtask

  task automatic a1(input logic cs, input logic we, input logic [3:0] ben,
                    input logic [31:0] d, input logic [3:0] ad);
    ifa1.CSel_S = cs; ifa1.WrEn_S = we; ifa1.BEn_S = ben; ifa1.WrData_D = d; ifa1.Addr_D = ad;
  endtask

  function automatic logic [63:0] w64(input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {8{b}};
  endfunction

  function automatic logic [31:0] w32(input int i);
    logic [7:0] b;
    b = 8'hC0 + 8'(i);
    return {4{b}};
  endfunction

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    a0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    b0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    a1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    ifb1.CSel_S = 1'b0; ifb1.WrEn_S = 1'b0; ifb1.BEn_S = 4'h0;
    ifb1.WrData_D = 32'h0; ifb1.Addr_D = 4'h0;
    #2;
    check("rst_vld_a0", {63'd0, ifa0.RdValid_S}, 64'd0);
    check("rst_vld_b0", {63'd0, ifb0.RdValid_S}, 64'd0);
    check("rst_coll0",  {63'd0, coll0}, 64'd0);
    check("rst_vld_a1", {63'd0, ifa1.RdValid_S}, 64'd0);
    check("rst_data_a1", {32'd0, ifa1.RdData_D}, 64'd0);
    check("rst_data_b1", {32'd0, ifb1.RdData_D}, 64'd0);
    tick();
    tick();
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // Full write on A, read back on B.
    a0(1'b1, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 10'h005);
    tick();
    check("wr_no_vld_a0", {63'd0, ifa0.RdValid_S}, 64'd0);
    a0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    b0(1'b1, 1'b0, 8'h00, 64'h0, 10'h005);
    tick();
    check("xrd_vld_b0", {63'd0, ifb0.RdValid_S}, 64'd1);
    check("xrd_data_b0", ifb0.RdData_D, 64'h0123_4567_89AB_CDEF);
    b0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    tick();
    check("vld_one_cycle_b0", {63'd0, ifb0.RdValid_S}, 64'd0);
    check("hold_data_b0", ifb0.RdData_D, 64'h0123_4567_89AB_CDEF);

    // Byte merge.
    a0(1'b1, 1'b1, 8'h0F, 64'hFFFF_FFFF_0000_0000, 10'h005);
    tick();
    a0(1'b1, 1'b0, 8'h00, 64'h0, 10'h005);
    tick();
    check("merge_a0", ifa0.RdData_D, 64'h0123_4567_0000_0000);

    // Read-first across ports.
    a0(1'b1, 1'b1, 8'hFF, 64'h5555_5555_5555_5555, 10'h010);
    tick();
    a0(1'b1, 1'b1, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 10'h010);
    b0(1'b1, 1'b0, 8'h00, 64'h0, 10'h010);
    tick();
    check("rdfirst_old_b0", ifb0.RdData_D, 64'h5555_5555_5555_5555);
    a0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    tick();
    check("rdfirst_new_b0", ifb0.RdData_D, 64'hAAAA_AAAA_AAAA_AAAA);

    // Write-write collision with overlapping byte enables.
    a0(1'b1, 1'b1, 8'hFF, 64'h3333_3333_3333_3333, 10'h020);
    b0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    tick();
    a0(1'b1, 1'b1, 8'h0F, 64'h1111_1111_1111_1111, 10'h020);
    b0(1'b1, 1'b1, 8'h3C, 64'h2222_2222_2222_2222, 10'h020);
    tick();
`ifdef SYNC_DP_RAM_COLL_CHECK_EN
    check("coll_set0", {63'd0, coll0}, 64'd1);
`else
    check("coll_tied0", {63'd0, coll0}, 64'd0);
`endif
    a0(1'b1, 1'b0, 8'h00, 64'h0, 10'h020);
    b0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    tick();
    check("coll_clear0", {63'd0, coll0}, 64'd0);
    check("coll_word_a0", ifa0.RdData_D, 64'h3333_2222_1111_1111);

    // Fill 0..7 two words per cycle, then stream 8 reads on A.
    for (int i = 0; i < 8; i += 2) begin
      a0(1'b1, 1'b1, 8'hFF, w64(i), 10'(i));
      b0(1'b1, 1'b1, 8'hFF, w64(i + 1), 10'(i + 1));
      tick();
    end
    b0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) a0(1'b1, 1'b0, 8'h00, 64'h0, 10'(i));
      else       a0(1'b0, 1'b0, 8'h00, 64'h0, 10'h0);
      tick();
      if (i < 8) begin
        check($sformatf("stream_vld_a0_%0d", i), {63'd0, ifa0.RdValid_S}, 64'd1);
        check($sformatf("stream_data_a0_%0d", i), ifa0.RdData_D, w64(i));
      end else begin
        check("stream_end_a0", {63'd0, ifa0.RdValid_S}, 64'd0);
      end
    end

    // dut1: fill, then stream with two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      a1(1'b1, 1'b1, 4'hF, w32(i), 4'(i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) a1(1'b1, 1'b0, 4'h0, 32'h0, 4'(i));
      else       a1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      tick();
      if (i == 0) begin
        check("stream_lat_a1", {63'd0, ifa1.RdValid_S}, 64'd0);
      end else if (i < 9) begin
        check($sformatf("stream_vld_a1_%0d", i - 1), {63'd0, ifa1.RdValid_S}, 64'd1);
        check($sformatf("stream_data_a1_%0d", i - 1), {32'd0, ifa1.RdData_D}, {32'd0, w32(i - 1)});
      end else begin
        check("stream_end_a1", {63'd0, ifa1.RdValid_S}, 64'd0);
      end
    end

    // Reset one cycle into a read.
    a1(1'b1, 1'b0, 4'h0, 32'h0, 4'h3);
    tick();
    a1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    rst1_n = 1'b0;
    #1;
    check("midrst_vld_a1", {63'd0, ifa1.RdValid_S}, 64'd0);
    check("midrst_data_a1", {32'd0, ifa1.RdData_D}, 64'd0);
    tick();
    rst1_n = 1'b1;
    tick();
    check("post_rst_vld1_a1", {63'd0, ifa1.RdValid_S}, 64'd0);
    tick();
    check("post_rst_vld2_a1", {63'd0, ifa1.RdValid_S}, 64'd0);
    a1(1'b1, 1'b0, 4'h0, 32'h0, 4'h3);
    tick();
    a1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    tick();
    check("retained_vld_a1", {63'd0, ifa1.RdValid_S}, 64'd1);
    check("retained_data_a1", {32'd0, ifa1.RdData_D}, {32'd0, w32(3)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
